fifo_stream_reader: RTL and testbench

- Read-side consumer for the team's synchronous FIFO.
- Drives the FIFO rd_en / empty / rd_data port, whose data is registered with 1-cycle read latency.
- Presents the data as a valid/ready stream with full throughput (1 beat/cycle) through a 2-entry prefetch buffer.
- Sits between the FIFO and downstream packet or DMA logic; also supplies a beat counter and an optional burst-last marker.

---
 rtl/fifo_stream_reader_if.sv | 36 +++
 rtl/fifo_stream_reader.sv | 120 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Bundle of FIFO read-port and output-stream signals for fifo_stream_reader.
// master: the reader. slave: the FIFO/consumer side.
// m_last_o exists only when STREAM_LAST_EN is defined.
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic                  en_i;
   logic                  clr_i;
   logic                  fifo_empty_i;
   logic                  fifo_rd_en_o;
   logic [DATA_WIDTH-1:0] fifo_rd_data_i;
   logic                  m_valid_o;
   logic [DATA_WIDTH-1:0] m_data_o;
   logic                  m_ready_i;
   logic [CNT_WIDTH-1:0]  beat_cnt_o;
`ifdef STREAM_LAST_EN
   logic                  m_last_o;
`endif

   modport master (
      input  en_i, clr_i, fifo_empty_i, fifo_rd_data_i, m_ready_i,
      output fifo_rd_en_o, m_valid_o, m_data_o, beat_cnt_o
`ifdef STREAM_LAST_EN
      , output m_last_o
`endif
   );

   modport slave (
      output en_i, clr_i, fifo_empty_i, fifo_rd_data_i, m_ready_i,
      input  fifo_rd_en_o, m_valid_o, m_data_o, beat_cnt_o
`ifdef STREAM_LAST_EN
      , input m_last_o
`endif
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// FIFO read-side consumer: turns a 1-cycle-latency FIFO read port into a
// full-throughput valid/ready stream via a 2-entry prefetch buffer.
// Optional macro STREAM_LAST_EN adds a burst counter and m_last_o.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int BURST_LEN  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   fifo_stream_reader_if.master  bus
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t                state;
   logic                  valid;
   logic [DATA_WIDTH-1:0] entry0;
   logic [DATA_WIDTH-1:0] entry1;
   logic                  inflight;
   logic                  discard;
   logic [CNT_WIDTH-1:0]  beat_cnt;

   logic                  pop;
   logic                  arr;
   logic                  rd_en;
   logic [1:0]            occ;
   logic [2:0]            level;

   if (BURST_LEN < 1) begin : g_bad_burst
      $error("BURST_LEN must be >= 1");
   end

   assign occ   = state;
   assign pop   = valid && bus.m_ready_i;
   assign arr   = inflight && !discard;
   // Occupancy after this cycle's pop plus words already requested; pop is
   // counted so a full buffer that drains one beat can refill in the same cycle.
   assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
   assign rd_en = !reset && bus.en_i && !bus.clr_i && !bus.fifo_empty_i && (level < 3'd2);

   assign bus.fifo_rd_en_o = rd_en;
   assign bus.m_valid_o    = valid;
   assign bus.m_data_o     = entry0;
   assign bus.beat_cnt_o   = beat_cnt;

   // Buffer occupancy FSM; entry0 is the stream head.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         valid  <= 1'b0;
         entry0 <= '0;
         entry1 <= '0;
      end else if (bus.clr_i) begin
         state <= EMPTY;
         valid <= 1'b0;
      end else begin
         case (state)
            EMPTY: if (arr) begin
               entry0 <= bus.fifo_rd_data_i;
               state  <= ONE;
               valid  <= 1'b1;
            end
            ONE: begin
               if (arr && !pop) begin
                  entry1 <= bus.fifo_rd_data_i;
                  state  <= TWO;
               end else if (arr && pop) begin
                  entry0 <= bus.fifo_rd_data_i;
               end else if (pop) begin
                  state <= EMPTY;
                  valid <= 1'b0;
               end
            end
            TWO: if (pop) begin
               entry0 <= entry1;
               if (arr) entry1 <= bus.fifo_rd_data_i;
               else     state  <= ONE;
            end
            default: begin
               state <= EMPTY;
               valid <= 1'b0;
            end
         endcase
      end
   end

   // Track the outstanding FIFO read; a read outstanding across clr is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight <= 1'b0;
         discard  <= 1'b0;
      end else begin
         inflight <= rd_en;
         discard  <= bus.clr_i && inflight;
      end
   end

   // Accepted-beat counter, wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          beat_cnt <= '0;
      else if (bus.clr_i) beat_cnt <= '0;
      else if (pop)       beat_cnt <= beat_cnt + 1'b1;
   end

`ifdef STREAM_LAST_EN
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN - 1);

   logic [BW-1:0] burst;

   assign bus.m_last_o = valid && (burst == BURST_MAX);

   // Position of the head beat within its burst.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          burst <= '0;
      else if (bus.clr_i) burst <= '0;
      else if (pop)       burst <= (burst == BURST_MAX) ? '0 : burst + 1'b1;
   end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 1-cycle FIFO.
module tb_fifo_stream_reader;
   localparam int DW = 32;
   localparam int CW = 4;
   localparam int BL = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fifo_stream_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST_LEN(BL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got[$];
   int            got_cyc[$];
`ifdef STREAM_LAST_EN
   logic          got_last[$];
`endif
   logic force_empty;
   int   underflow = 0;
   int   viol = 0;
   int   cyc = 0;
   int   first_rd, first_vld, rd_cnt, exp_cnt;
   logic last_rd;
   int   n_chk = 0;
   int   n_pass = 0;

   // FIFO model: registered read data, one word per rd_en cycle.
   always @(posedge clk) begin
      if (bus.fifo_rd_en_o) begin
         if (fq.size() > 0) bus.fifo_rd_data_i <= fq.pop_front();
         else               underflow <= underflow + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   // One clock: present empty flag, record this cycle's events, step the edge.
   task automatic tick();
      bus.fifo_empty_i = (fq.size() == 0) || force_empty;
      #1;
      last_rd = bus.fifo_rd_en_o;
      if (bus.fifo_rd_en_o) begin
         rd_cnt++;
         if (first_rd < 0) first_rd = cyc;
      end
      if (bus.m_valid_o && first_vld < 0) first_vld = cyc;
      if (dut.occ == 2'd2 && dut.arr && !dut.pop) viol++;
      if (bus.m_valid_o && bus.m_ready_i) begin
         got.push_back(bus.m_data_o);
         got_cyc.push_back(cyc);
`ifdef STREAM_LAST_EN
         got_last.push_back(bus.m_last_o);
`endif
      end
      if (bus.clr_i) exp_cnt = 0;
      else if (bus.m_valid_o && bus.m_ready_i) exp_cnt++;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      int hold_err, drop_err, errs, pushed, n;
      logic seen;
      logic [DW-1:0] w;
      logic [31:0] mask;

      bus.en_i = 1'b1;
      bus.clr_i = 1'b0;
      bus.m_ready_i = 1'b1;
      bus.fifo_rd_data_i = '0;
      bus.fifo_empty_i = 1'b0;
      force_empty = 1'b0;
      first_rd = -1; first_vld = -1; rd_cnt = 0; exp_cnt = 0;
      for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));

      // Reset state, with data available: no reads while in reset.
      repeat (2) @(posedge clk);
      #2;
      chk("rst_rd_en", {31'd0, bus.fifo_rd_en_o}, 0);
      chk("rst_valid", {31'd0, bus.m_valid_o}, 0);
      chk("rst_data", bus.m_data_o, 0);
      chk("rst_cnt", 32'(bus.beat_cnt_o), 0);
      reset = 1'b0;

      // Streaming 8 preloaded words with ready held high.
      repeat (14) tick();
      chk("t1_latency", 32'(first_vld - first_rd), 2);
      chk("t1_count", got.size(), 8);
      for (int i = 0; i < 8; i++)
         chk("t1_data", (i < got.size()) ? got[i] : 32'hdead_beef, 32'(i + 1));
      chk("t1_gap", (got.size() == 8) ? 32'(got_cyc[7] - got_cyc[0]) : 32'hffff_ffff, 7);
      chk("t1_cnt", 32'(bus.beat_cnt_o), 8);
      chk("t1_valid_end", {31'd0, bus.m_valid_o}, 0);

      // Backpressure: only two reads fit, head holds steady.
      bus.m_ready_i = 1'b0;
      got.delete(); got_cyc.delete();
      for (int i = 1; i <= 5; i++) fq.push_back(DW'(i));
      rd_cnt = 0; hold_err = 0; drop_err = 0; seen = 1'b0;
      repeat (10) begin
         tick();
         if (bus.m_valid_o) begin
            seen = 1'b1;
            if (bus.m_data_o != 1) hold_err++;
         end else if (seen) drop_err++;
      end
      chk("bp_reads", rd_cnt, 2);
      chk("bp_hold", hold_err, 0);
      chk("bp_drop", drop_err, 0);
      chk("bp_head", bus.m_data_o, 1);
      bus.m_ready_i = 1'b1;
      for (int k = 0; k < 30 && got.size() < 5; k++) tick();
      chk("bp_count", got.size(), 5);
      for (int i = 0; i < 5; i++)
         chk("bp_data", (i < got.size()) ? got[i] : 32'hdead_beef, 32'(i + 1));
      chk("bp_cnt", 32'(bus.beat_cnt_o), 13);

      // Random ready, sparse writes and a flickering empty flag.
      got.delete(); got_cyc.delete(); exp_q.delete();
      pushed = 0;
      for (int c = 0; c < 20000 && got.size() < 1000; c++) begin
         bus.m_ready_i = 1'($urandom_range(0, 1));
         if (pushed < 1000 && $urandom_range(0, 2) != 0) begin
            w = $urandom;
            fq.push_back(w);
            exp_q.push_back(w);
            pushed++;
         end
         force_empty = ($urandom_range(0, 3) == 0);
         tick();
      end
      force_empty = 1'b0;
      bus.m_ready_i = 1'b1;
      errs = 0;
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) errs++;
      chk("rnd_count", got.size(), 1000);
      chk("rnd_order", errs, 0);
      chk("rnd_two_arr", viol, 0);
      chk("rnd_underflow", underflow, 0);
      chk("rnd_cnt_wrap", 32'(bus.beat_cnt_o), 32'(exp_cnt % 16));

      // clr with a read outstanding and the buffer loaded.
      bus.m_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) fq.push_back(32'h11 + i);
      repeat (4) tick();
      chk("clr_pre_head", bus.m_data_o, 32'h11);
      bus.m_ready_i = 1'b1;
      tick();
      chk("clr_pre_head2", bus.m_data_o, 32'h12);
      bus.m_ready_i = 1'b0;
      bus.clr_i = 1'b1;
      tick();
      chk("clr_rd_en", {31'd0, last_rd}, 0);
      chk("clr_valid", {31'd0, bus.m_valid_o}, 0);
      chk("clr_cnt", 32'(bus.beat_cnt_o), 0);
      bus.clr_i = 1'b0;
      got.delete(); got_cyc.delete();
      fq.push_back(32'h15);
      bus.m_ready_i = 1'b1;
      for (int k = 0; k < 20 && got.size() < 2; k++) tick();
      chk("clr_after_n", got.size(), 2);
      chk("clr_after0", (got.size() > 0) ? got[0] : 32'hdead_beef, 32'h14);
      chk("clr_after1", (got.size() > 1) ? got[1] : 32'hdead_beef, 32'h15);
      chk("clr_after_cnt", 32'(bus.beat_cnt_o), 2);

      // en_i drops while a read is outstanding.
      got.delete(); got_cyc.delete();
      for (int i = 0; i < 3; i++) fq.push_back(32'h21 + i);
      tick();
      chk("en_issue", {31'd0, last_rd}, 1);
      bus.en_i = 1'b0;
      rd_cnt = 0;
      repeat (5) tick();
      chk("en_no_reads", rd_cnt, 0);
      chk("en_inflight_n", got.size(), 1);
      chk("en_inflight", (got.size() > 0) ? got[0] : 32'hdead_beef, 32'h21);
      bus.en_i = 1'b1;
      for (int k = 0; k < 20 && got.size() < 3; k++) tick();
      chk("en_resume1", (got.size() > 1) ? got[1] : 32'hdead_beef, 32'h22);
      chk("en_resume2", (got.size() > 2) ? got[2] : 32'hdead_beef, 32'h23);

`ifdef STREAM_LAST_EN
      // Burst markers with BURST_LEN=4 over 10 beats.
      bus.clr_i = 1'b1;
      tick();
      bus.clr_i = 1'b0;
      got.delete(); got_cyc.delete(); got_last.delete();
      for (int i = 0; i < 10; i++) fq.push_back(32'h31 + i);
      for (int k = 0; k < 40 && got.size() < 10; k++) tick();
      mask = '0;
      for (int i = 0; i < got_last.size() && i < 32; i++) mask[i] = got_last[i];
      chk("last_mask", mask, 32'h88);
      chk("last_cnt", 32'(bus.beat_cnt_o), 10);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
